// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 divider (div.w/mod.w/div.wu/mod.wu) answering the EXE divide handshake.
// 33 cycles from the enable being seen in IDLE to complete; DONE holds until div_fire or a flush.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_enable,
  input  logic        div_sign,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_fire,
  output logic        div_complete,
  output logic [31:0] div_quotient,
  output logic [31:0] div_remainder
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic        s1_neg;
  logic        s2_neg;
  logic        div_zero;
  logic [31:0] src1_raw;
  logic [31:0] divisor;
  logic [31:0] dvd;
  logic [31:0] rem;

  logic [32:0] shifted;
  logic [31:0] trial;
  logic        qbit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [31:0] q_final;
  logic [31:0] r_final;

  always_comb begin
    mag1 = (div_sign && div_src1[31]) ? (~div_src1 + 32'd1) : div_src1;
    mag2 = (div_sign && div_src2[31]) ? (~div_src2 + 32'd1) : div_src2;
  end

  // The low 32 bits of the subtraction are exact whenever the trial is
  // non-negative, since the result is then smaller than the divisor.
  always_comb begin
    shifted  = {rem, dvd[31]};
    qbit     = (shifted >= {1'b0, divisor});
    trial    = shifted[31:0] - divisor;
    rem_next = qbit ? trial : shifted[31:0];
    quo_next = {dvd[30:0], qbit};
  end

  always_comb begin
    if (div_zero) begin
      q_final = 32'hFFFF_FFFF;
      r_final = src1_raw;
    end else begin
      q_final = (s1_neg ^ s2_neg) ? (~quo_next + 32'd1) : quo_next;
      r_final = s1_neg ? (~rem_next + 32'd1) : rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 5'd0;
      s1_neg        <= 1'b0;
      s2_neg        <= 1'b0;
      div_zero      <= 1'b0;
      src1_raw      <= 32'd0;
      divisor       <= 32'd0;
      dvd           <= 32'd0;
      rem           <= 32'd0;
      div_quotient  <= 32'd0;
      div_remainder <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (div_enable) begin
            s1_neg   <= div_sign & div_src1[31];
            s2_neg   <= div_sign & div_src2[31];
            div_zero <= (div_src2 == 32'd0);
            src1_raw <= div_src1;
            dvd      <= mag1;
            divisor  <= mag2;
            rem      <= 32'd0;
            count    <= 5'd0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!div_enable) begin
            state <= IDLE;
          end else begin
            rem   <= rem_next;
            dvd   <= quo_next;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              div_quotient  <= q_final;
              div_remainder <= r_final;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (div_fire || !div_enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_complete = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, divide by zero,
// overflow, backpressure, back-to-back, flush and mid-operation reset.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        div_enable;
  logic        div_sign;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_fire;
  logic        div_complete;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .reset        (reset),
    .div_enable   (div_enable),
    .div_sign     (div_sign),
    .div_src1     (div_src1),
    .div_src2     (div_src2),
    .div_fire     (div_fire),
    .div_complete (div_complete),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b);
    div_sign   = s;
    div_src1   = a;
    div_src2   = b;
    div_enable = 1'b1;
  endtask

  // Counts negedges until complete; a missing completion shows up as a wrong latency.
  task automatic wait_complete(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!div_complete && cyc < 60);
  endtask

  task automatic do_div(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int cyc;
    start(s, a, b);
    wait_complete(cyc);
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected 33", name, cyc);
    end
    checks++;
    if (div_quotient !== eq) begin
      errors++;
      $display("FAIL %s quotient: got %h expected %h", name, div_quotient, eq);
    end
    checks++;
    if (div_remainder !== er) begin
      errors++;
      $display("FAIL %s remainder: got %h expected %h", name, div_remainder, er);
    end
    div_fire = 1'b1;
    @(negedge clk);
    div_fire   = 1'b0;
    div_enable = 1'b0;
    checks++;
    if (div_complete !== 1'b0 || div_quotient !== eq || div_remainder !== er) begin
      errors++;
      $display("FAIL %s after fire: got complete=%b q=%h r=%h expected complete=0 q=%h r=%h",
               name, div_complete, div_quotient, div_remainder, eq, er);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start(1'b0, 32'd100, 32'd7);
    div_fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (div_complete !== 1'b0 || div_quotient !== 32'd0 || div_remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset state: got complete=%b q=%h r=%h expected 0 0 0",
               div_complete, div_quotient, div_remainder);
    end
    div_enable = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    do_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
  endtask

  task automatic test_signed();
    do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
  endtask

  task automatic test_div_zero();
    do_div("s-7/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    do_div("u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
  endtask

  task automatic test_overflow();
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    do_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_back_to_back();
    int cyc;
    start(1'b0, 32'd1000, 32'd7);
    wait_complete(cyc);
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("FAIL bp latency: got %0d cycles expected 33", cyc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (div_complete !== 1'b1 || div_quotient !== 32'd142 || div_remainder !== 32'd6) begin
        errors++;
        $display("FAIL bp hold %0d: got complete=%b q=%h r=%h expected 1 %h %h",
                 i, div_complete, div_quotient, div_remainder, 32'd142, 32'd6);
      end
    end
    div_fire = 1'b1;
    div_src1 = 32'd9;
    div_src2 = 32'd4;
    @(negedge clk);
    div_fire = 1'b0;
    checks++;
    if (div_complete !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: got complete=%b expected 0", div_complete);
    end
    wait_complete(cyc);
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("FAIL b2b latency: got %0d cycles expected 33", cyc);
    end
    checks++;
    if (div_quotient !== 32'd2 || div_remainder !== 32'd1) begin
      errors++;
      $display("FAIL b2b result: got q=%h r=%h expected q=2 r=1", div_quotient, div_remainder);
    end
    div_fire = 1'b1;
    @(negedge clk);
    div_fire   = 1'b0;
    div_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic seen;
    start(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    div_enable = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_complete !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush complete: got asserted expected never");
    end
    checks++;
    if (div_quotient !== 32'd2 || div_remainder !== 32'd1) begin
      errors++;
      $display("FAIL flush outputs: got q=%h r=%h expected q=2 r=1", div_quotient, div_remainder);
    end
    do_div("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
  endtask

  task automatic test_reset_busy();
    start(1'b0, 32'd50, 32'd5);
    repeat (5) @(negedge clk);
    reset      = 1'b1;
    div_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (div_complete !== 1'b0 || div_quotient !== 32'd0 || div_remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset busy: got complete=%b q=%h r=%h expected 0 0 0",
               div_complete, div_quotient, div_remainder);
    end
    do_div("u50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    div_enable = 1'b0;
    div_sign   = 1'b0;
    div_src1   = 32'd0;
    div_src2   = 32'd0;
    div_fire   = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
